router_pkt_tx: RTL and testbench

Packet source for the 1x3 router input port. Takes a packet request (destination address and payload length), pulls payload bytes from an upstream byte source, and drives the router's byte-wide input bus with the framed packet: header, payload, then parity. It honours the router's `busy` back-pressure and keeps counters of packets sent and router-reported errors. It sits between the stimulus or host logic and the router top.

---
 rtl/router_pkt_tx_if.sv | 28 ++
 rtl/router_pkt_tx.sv | 94 +++++++++
 tb/tb_router_pkt_tx.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/router_pkt_tx_if.sv
// router_pkt_tx_if: request, payload-source and router-bus signals of the packet transmitter
interface router_pkt_tx_if;
    logic        start;
    logic [1:0]  addr;
    logic [5:0]  len;
    logic        corrupt;
    logic [7:0]  pay_data;
    logic        pay_rd;
    logic        busy;
    logic        err;
    logic [7:0]  data;
    logic        pktvalid;
    logic        ready;
    logic        done;
    logic        addr_err;
    logic [15:0] pkt_cnt;
    logic [7:0]  err_cnt;

    modport master (
        input  start, addr, len, corrupt, pay_data, busy, err,
        output pay_rd, data, pktvalid, ready, done, addr_err, pkt_cnt, err_cnt
    );

    modport slave (
        output start, addr, len, corrupt, pay_data, busy, err,
        input  pay_rd, data, pktvalid, ready, done, addr_err, pkt_cnt, err_cnt
    );
endinterface

// File: rtl/router_pkt_tx.sv
// router_pkt_tx: frames header/payload/parity onto the router input bus; ROUTER_PKT_TX_CORRUPT_EN enables parity inversion
module router_pkt_tx #(
    parameter int MAXLEN = 63
) (
    input logic            clk,
    input logic            reset,
    router_pkt_tx_if.master bus
);
    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, PARITY} state_t;

    localparam logic [6:0] MAX7 = 7'(MAXLEN);

    state_t     state;
    logic [5:0] rem;
    logic [7:0] par;
    logic       inv;
    logic       err_q;
    logic [5:0] len_c;

    assign len_c     = ({1'b0, bus.len} > MAX7) ? MAX7[5:0] : bus.len;
    assign bus.ready = state == IDLE;

    // packet framing FSM; every byte advance waits for busy=0
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            bus.data     <= '0;
            bus.pktvalid <= 1'b0;
            bus.pay_rd   <= 1'b0;
            bus.done     <= 1'b0;
            bus.addr_err <= 1'b0;
            bus.pkt_cnt  <= '0;
            rem          <= '0;
            par          <= '0;
            inv          <= 1'b0;
        end else begin
            bus.pay_rd   <= 1'b0;
            bus.done     <= 1'b0;
            bus.addr_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.addr == 2'd3) begin
                            bus.addr_err <= 1'b1;
                        end else begin
                            rem          <= len_c;
                            bus.data     <= {len_c, bus.addr};
                            par          <= {len_c, bus.addr};
                            bus.pktvalid <= 1'b1;
`ifdef ROUTER_PKT_TX_CORRUPT_EN
                            inv          <= bus.corrupt;
`else
                            inv          <= 1'b0;
`endif
                            state        <= HEADER;
                        end
                    end
                end
                HEADER, PAYLOAD: begin
                    if (!bus.busy) begin
                        if (rem != 6'd0) begin
                            bus.data   <= bus.pay_data;
                            bus.pay_rd <= 1'b1;
                            par        <= par ^ bus.pay_data;
                            rem        <= rem - 6'd1;
                            state      <= PAYLOAD;
                        end else begin
                            bus.data     <= par ^ {8{inv}};
                            bus.pktvalid <= 1'b0;
                            state        <= PARITY;
                        end
                    end
                end
                default: begin
                    if (!bus.busy) begin
                        bus.data    <= '0;
                        bus.done    <= 1'b1;
                        bus.pkt_cnt <= bus.pkt_cnt + 16'd1;
                        state       <= IDLE;
                    end
                end
            endcase
        end
    end

    // saturating count of err rising edges; an err already high through reset is not an edge
    always_ff @(posedge clk) begin
        err_q <= bus.err;
        if (reset)
            bus.err_cnt <= '0;
        else if (bus.err && !err_q && bus.err_cnt != 8'hFF)
            bus.err_cnt <= bus.err_cnt + 8'd1;
    end
endmodule

// File: tb/tb_router_pkt_tx.sv
// tb_router_pkt_tx: directed literal checks plus randomized traffic against a packet-list model
module tb_router_pkt_tx;
    localparam int MAXLEN = 40;
`ifdef ROUTER_PKT_TX_CORRUPT_EN
    localparam bit CORR = 1'b1;
`else
    localparam bit CORR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    router_pkt_tx_if bus();
    router_pkt_tx #(.MAXLEN(MAXLEN)) dut (.clk(clk), .reset(reset), .bus(bus));

    int total = 0;
    int bad = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // upstream byte source: advances once per observed pay_rd pulse
    logic [7:0] mem [4096];
    int src_idx = 0;

    // model: current packet as a byte list plus position (-1 = idle)
    int         pos = -1;
    int         nbytes = 0;
    logic [7:0] pkt [66];
    logic [7:0] m_data = 0;
    logic       m_pv = 0, m_rd = 0, m_done = 0, m_aerr = 0, m_errp = 0;
    logic [15:0] m_pc = 0;
    logic [7:0]  m_ec = 0;
    bit          chk_en = 0;

    task automatic model_step();
        int l;
        logic [7:0] p;
        if (reset) begin
            pos = -1; m_rd = 0; m_done = 0; m_aerr = 0; m_pc = 0; m_ec = 0; m_errp = bus.err;
        end else begin
            m_rd = 0; m_done = 0; m_aerr = 0;
            if (bus.err && !m_errp && m_ec != 8'hFF) m_ec++;
            m_errp = bus.err;
            if (pos < 0) begin
                if (bus.start) begin
                    if (bus.addr == 2'd3) m_aerr = 1;
                    else begin
                        l = (int'(bus.len) > MAXLEN) ? MAXLEN : int'(bus.len);
                        pkt[0] = {6'(l), bus.addr};
                        p = pkt[0];
                        for (int i = 0; i < l; i++) begin
                            pkt[i+1] = mem[(src_idx + i) % 4096];
                            p ^= pkt[i+1];
                        end
                        pkt[l+1] = p ^ ((CORR && bus.corrupt) ? 8'hFF : 8'h00);
                        nbytes = l + 2;
                        pos = 0;
                    end
                end
            end else if (!bus.busy) begin
                pos++;
                if (pos == nbytes) begin
                    pos = -1; m_done = 1; m_pc++;
                end else m_rd = pos < nbytes - 1;
            end
        end
        m_data = pos < 0 ? 8'h00 : pkt[pos];
        m_pv = pos >= 0 && pos < nbytes - 1;
    endtask

    initial begin
        foreach (mem[i]) mem[i] = 8'($urandom);
        bus.pay_data = mem[0];
        forever begin
            @(posedge clk);
            #1;
            if (bus.pay_rd === 1'b1) src_idx = (src_idx + 1) % 4096;
            bus.pay_data = mem[src_idx];
        end
    end

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // capture of accepted bytes for the directed literal checks
    bit         cap_on = 0;
    logic [7:0] cap_q [$];
    logic       cap_pv [$];
    int         rd_n = 0, done_n = 0, hold_seen = 0;
    logic [7:0] hold_byte = 0;

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("data", bus.data, m_data);
            check("pktvalid", bus.pktvalid, m_pv);
            check("ready", bus.ready, pos < 0);
            check("pay_rd", bus.pay_rd, m_rd);
            check("done", bus.done, m_done);
            check("addr_err", bus.addr_err, m_aerr);
            check("pkt_cnt", bus.pkt_cnt, m_pc);
            check("err_cnt", bus.err_cnt, m_ec);
        end
        if (cap_on) begin
            if (bus.ready === 1'b0 && bus.busy === 1'b0) begin
                cap_q.push_back(bus.data);
                cap_pv.push_back(bus.pktvalid);
            end
            if (bus.pay_rd === 1'b1) rd_n++;
            if (bus.done === 1'b1) done_n++;
            if (bus.ready === 1'b0 && bus.pktvalid === 1'b1 && bus.data === hold_byte) hold_seen++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic load3(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        mem[src_idx % 4096] = b0;
        mem[(src_idx + 1) % 4096] = b1;
        mem[(src_idx + 2) % 4096] = b2;
        bus.pay_data = mem[src_idx];
    endtask

    task automatic run_pkt(input logic [1:0] a, input logic [5:0] l, input logic c, input logic [7:0] hb, input int hold_n);
        int held = 0;
        cap_q.delete(); cap_pv.delete();
        rd_n = 0; done_n = 0; hold_seen = 0; hold_byte = hb;
        bus.start = 1; bus.addr = a; bus.len = l; bus.corrupt = c; cap_on = 1;
        tick();
        bus.start = 0;
        for (int i = 0; i < 200 && done_n == 0; i++) begin
            bus.busy = held < hold_n && bus.pktvalid === 1'b1 && bus.data === hb;
            if (bus.busy) held++;
            tick();
        end
        bus.busy = 0; cap_on = 0;
        if (done_n == 0) check("pkt_timeout", 0, 1);
    endtask

    task automatic check_bytes(input string name, input logic [7:0] e[$]);
        check({name, "_nbytes"}, cap_q.size(), e.size());
        for (int i = 0; i < e.size() && i < cap_q.size(); i++) begin
            check({name, "_byte"}, cap_q[i], e[i]);
            check({name, "_pv"}, cap_pv[i], i < e.size() - 1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] e [$];
        bus.start = 0; bus.addr = 0; bus.len = 0; bus.corrupt = 0; bus.busy = 0; bus.err = 0;
        reset = 1;
        repeat (3) tick();
        chk_en = 1;
        reset = 0;
        check("rst_ready", bus.ready, 1);
        check("rst_data", bus.data, 0);
        check("rst_pkt_cnt", bus.pkt_cnt, 0);
        check("rst_err_cnt", bus.err_cnt, 0);

        load3(8'h11, 8'h22, 8'h33);
        run_pkt(2'd1, 6'd3, 1'b0, 8'h00, 0);
        e = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
        check_bytes("basic", e);
        check("basic_rd", rd_n, 3);
        check("basic_done", done_n, 1);
        check("basic_cnt", bus.pkt_cnt, 1);

        tick();
        load3(8'h11, 8'h22, 8'h33);
        run_pkt(2'd1, 6'd3, 1'b0, 8'h22, 2);
        check_bytes("bp", e);
        check("bp_hold", hold_seen, 3);
        check("bp_rd", rd_n, 3);

        tick();
        run_pkt(2'd2, 6'd0, 1'b0, 8'h00, 0);
        e = '{8'h02, 8'h02};
        check_bytes("zero", e);
        check("zero_rd", rd_n, 0);
        check("zero_done", done_n, 1);

        bus.start = 1; bus.addr = 2'd3; bus.len = 6'd4;
        tick();
        bus.start = 0;
        @(negedge clk);
        check("ill_addr_err", bus.addr_err, 1);
        check("ill_ready", bus.ready, 1);
        check("ill_data", bus.data, 0);
        check("ill_pv", bus.pktvalid, 0);
        check("ill_cnt", bus.pkt_cnt, 3);
        tick();

        run_pkt(2'd1, 6'd50, 1'b0, 8'h00, 0);
        check("clamp_hdr", cap_q.size() > 0 ? cap_q[0] : 8'h00, 8'hA1);
        check("clamp_nbytes", cap_q.size(), 42);
        check("clamp_rd", rd_n, 40);
        tick();

        rd_n = 0; cap_on = 1;
        bus.start = 1; bus.addr = 2'd0; bus.len = 6'd5;
        tick();
        bus.start = 0;
        for (int i = 0; i < 50 && rd_n < 2; i++) tick();
        cap_on = 0;
        check("mid_rd", rd_n, 2);
        reset = 1;
        tick();
        reset = 0;
        @(negedge clk);
        check("mid_pv", bus.pktvalid, 0);
        check("mid_data", bus.data, 0);
        check("mid_ready", bus.ready, 1);
        check("mid_cnt", bus.pkt_cnt, 0);
        bus.err = 1; tick();
        bus.err = 0; tick();
        bus.err = 1; tick();
        @(negedge clk);
        check("err_cnt2", bus.err_cnt, 2);
        bus.err = 0; tick();

        load3(8'h11, 8'h22, 8'h33);
        run_pkt(2'd1, 6'd3, 1'b1, 8'h00, 0);
        check("corrupt_par", cap_q.size() == 5 ? cap_q[4] : 8'h00, CORR ? 8'hF2 : 8'h0D);
        tick();

        for (int i = 0; i < 5000; i++) begin
            reset = ($urandom % 400) == 0;
            bus.start = ($urandom % 3) == 0;
            bus.addr = 2'($urandom_range(0, 3));
            bus.len = ($urandom % 10 == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 9));
            bus.corrupt = 1'($urandom);
            bus.busy = ($urandom % 4) == 0;
            if ($urandom % 8 == 0) bus.err = ~bus.err;
            tick();
        end
        reset = 0; bus.start = 0; bus.busy = 0;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
